// File: rtl/if_id_fetch_stage_pkg.sv
// Shared definitions for the fetch stage: predictor counter encoding, NOP and reset PC.
package if_id_fetch_stage_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_e;

  localparam logic [31:0] NOP_INST     = 32'h0;
  localparam int unsigned RESET_PC_DEF = 0;

  // Two-bit saturating counter step toward the resolved outcome.
  function automatic bht_ctr_e ctr_update(bht_ctr_e cur, logic taken);
    logic [1:0] v;
    v = cur;
    if (taken) begin
      if (v != 2'b11) v = v + 2'd1;
    end else begin
      if (v != 2'b00) v = v - 2'd1;
    end
    return bht_ctr_e'(v);
  endfunction

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// Bus between the fetch stage and its neighbours: hazard/EX control in, imem and IF/ID out.
interface if_id_fetch_stage_if #(
  parameter int PC_W = 32
);
  logic            STALL;
  logic            FLUSH;
  logic            EX_redirect;
  logic [PC_W-1:0] EX_PFC;
  logic            EX_upd_valid;
  logic [PC_W-1:0] EX_upd_PC;
  logic            EX_upd_taken;
  logic [PC_W-1:0] EX_upd_target;
  logic [PC_W-1:0] IF_PC;
  logic [31:0]     IF_inst;
  logic [31:0]     ID_inst;
  logic [PC_W-1:0] ID_PC;
  logic            ID_predicted;
  logic [PC_W-1:0] ID_PFC;

  modport master (
    output STALL, FLUSH, EX_redirect, EX_PFC,
    output EX_upd_valid, EX_upd_PC, EX_upd_taken, EX_upd_target,
    output IF_inst,
    input  IF_PC, ID_inst, ID_PC, ID_predicted, ID_PFC
  );

  modport slave (
    input  STALL, FLUSH, EX_redirect, EX_PFC,
    input  EX_upd_valid, EX_upd_PC, EX_upd_taken, EX_upd_target,
    input  IF_inst,
    output IF_PC, ID_inst, ID_PC, ID_predicted, ID_PFC
  );
endinterface

// File: rtl/if_id_fetch_stage_branch_predictor_table.sv
// Direct-mapped 2-bit BHT plus BTB: combinational lookup port, single registered update port.
module if_id_fetch_stage_branch_predictor_table
  import if_id_fetch_stage_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = PC_W - IDX_W;

  bht_ctr_e          bht        [ENTRIES];
  logic [ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]  btb_tag    [ENTRIES];
  logic [PC_W-1:0]   btb_target [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  bht_ctr_e         lk_ctr;

  assign lk_idx = lookup_pc[IDX_W-1:0];
  assign lk_tag = lookup_pc[PC_W-1:IDX_W];
  assign up_idx = upd_pc[IDX_W-1:0];
  assign up_tag = upd_pc[PC_W-1:IDX_W];
  assign lk_ctr = bht[lk_idx];

  // Lookup reads the registered arrays, so a same-cycle update is not bypassed.
  assign pred_taken  = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag) && lk_ctr[1];
  assign pred_target = btb_target[lk_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i]        <= WNT;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (upd_valid) begin
      bht[up_idx] <= ctr_update(bht[up_idx], upd_taken);
      if (upd_taken) begin
        btb_valid[up_idx]  <= 1'b1;
        btb_tag[up_idx]    <= up_tag;
        btb_target[up_idx] <= upd_target;
      end
    end
  end

endmodule

// File: rtl/if_id_fetch_stage.sv
// Fetch stage: PC register, next-PC selection with dynamic prediction, IF/ID pipeline register.
module if_id_fetch_stage
  import if_id_fetch_stage_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              IDX_W    = 4,
  parameter int              PC_INC   = 1,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic clk,
  input  logic rst,
  if_id_fetch_stage_if.slave bus
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pnext;
  logic [PC_W-1:0] pred_target;
  logic            pred_taken;

  logic [31:0]     id_inst_q;
  logic [PC_W-1:0] id_pc_q;
  logic            id_pred_q;
  logic [PC_W-1:0] id_pfc_q;

  if_id_fetch_stage_branch_predictor_table #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W)
  ) u_bpt (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc   (pc_q),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (bus.EX_upd_valid),
    .upd_pc      (bus.EX_upd_PC),
    .upd_taken   (bus.EX_upd_taken),
    .upd_target  (bus.EX_upd_target)
  );

  assign pnext = pred_taken ? pred_target : pc_q + PC_W'(PC_INC);

  // A redirect from EX overrides a stall request from the hazard unit.
  always_comb begin
    pc_d = pnext;
    if (bus.EX_redirect) begin
      pc_d = bus.EX_PFC;
    end else if (bus.STALL) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_inst_q <= NOP_INST;
      id_pc_q   <= '0;
      id_pred_q <= 1'b0;
      id_pfc_q  <= '0;
    end else if (bus.FLUSH || bus.EX_redirect) begin
      id_inst_q <= NOP_INST;
      id_pc_q   <= '0;
      id_pred_q <= 1'b0;
      id_pfc_q  <= '0;
    end else if (!bus.STALL) begin
      id_inst_q <= bus.IF_inst;
      id_pc_q   <= pc_q;
      id_pred_q <= pred_taken;
      id_pfc_q  <= pnext;
    end
  end

  assign bus.IF_PC        = pc_q;
  assign bus.ID_inst      = id_inst_q;
  assign bus.ID_PC        = id_pc_q;
  assign bus.ID_predicted = id_pred_q;
  assign bus.ID_PFC       = id_pfc_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench for if_id_fetch_stage: directed scenarios followed by randomized traffic.
module tb_if_id_fetch_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;

  if_id_fetch_stage_if #(.PC_W(32)) bus ();

  if_id_fetch_stage #(
    .PC_W     (32),
    .IDX_W    (4),
    .PC_INC   (1),
    .RESET_PC (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5671;
  endfunction

  logic        force_en  = 1'b0;
  logic [31:0] force_val = 32'h0;
  assign bus.IF_inst = force_en ? force_val : imem(bus.IF_PC);

  typedef struct {
    logic [31:0] if_pc;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_pred;
    logic [31:0] id_pfc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: architectural state in plain variables
  logic [31:0] m_pc, m_id_inst, m_id_pc, m_id_pfc;
  logic        m_id_pred;
  int          m_ctr [16];
  bit          m_val [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];

  // Stimulus for the next cycle
  logic        t_stall, t_flush, t_redir, t_uv, t_ut, t_fen;
  logic [31:0] t_pfc, t_upc, t_utgt, t_fval;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_stim();
    t_stall = 0; t_flush = 0; t_redir = 0; t_uv = 0; t_ut = 0; t_fen = 0;
    t_pfc = 0; t_upc = 0; t_utgt = 0; t_fval = 0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_id_inst = 0; m_id_pc = 0; m_id_pfc = 0; m_id_pred = 0;
    for (int i = 0; i < 16; i++) begin
      m_ctr[i] = 1; m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
    end
  endtask

  task automatic tick();
    exp_t        e;
    int          idx, ui;
    bit          pt;
    logic [31:0] pn, inst;
    @(negedge clk);
    bus.STALL         = t_stall;
    bus.FLUSH         = t_flush;
    bus.EX_redirect   = t_redir;
    bus.EX_PFC        = t_pfc;
    bus.EX_upd_valid  = t_uv;
    bus.EX_upd_PC     = t_upc;
    bus.EX_upd_taken  = t_ut;
    bus.EX_upd_target = t_utgt;
    force_en          = t_fen;
    force_val         = t_fval;

    idx  = int'(m_pc % 16);
    pt   = m_val[idx] && (m_tag[idx] == m_pc / 16) && (m_ctr[idx] >= 2);
    pn   = pt ? m_tgt[idx] : m_pc + 32'd1;
    inst = t_fen ? t_fval : imem(m_pc);

    if (t_flush || t_redir) begin
      m_id_inst = 0; m_id_pc = 0; m_id_pred = 0; m_id_pfc = 0;
    end else if (!t_stall) begin
      m_id_inst = inst; m_id_pc = m_pc; m_id_pred = pt; m_id_pfc = pn;
    end

    if (t_redir) m_pc = t_pfc;
    else if (!t_stall) m_pc = pn;

    if (t_uv) begin
      ui = int'(t_upc % 16);
      if (t_ut) begin
        m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
        m_val[ui] = 1;
        m_tag[ui] = t_upc / 16;
        m_tgt[ui] = t_utgt;
      end else begin
        m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
      end
    end

    e.if_pc = m_pc; e.id_inst = m_id_inst; e.id_pc = m_id_pc;
    e.id_pred = m_id_pred; e.id_pfc = m_id_pfc;
    exp_q.push_back(e);
    clear_stim();
    @(posedge clk);
    #2;
  endtask

  task automatic upd(logic [31:0] pc, logic taken, logic [31:0] tgt);
    t_uv = 1; t_upc = pc; t_ut = taken; t_utgt = tgt;
    tick();
  endtask

  task automatic redir(logic [31:0] pc);
    t_redir = 1; t_pfc = pc;
    tick();
  endtask

  task automatic do_reset(bit pending_upd);
    @(negedge clk);
    bus.STALL = 0; bus.FLUSH = 0; bus.EX_redirect = 0; bus.EX_PFC = 0;
    bus.EX_upd_valid  = pending_upd;
    bus.EX_upd_PC     = 32'd7;
    bus.EX_upd_taken  = 1'b1;
    bus.EX_upd_target = 32'd9;
    force_en = 0;
    rst = 1'b1;
    #1;
    chk("rst_IF_PC", bus.IF_PC, 32'h0);
    chk("rst_ID_inst", bus.ID_inst, 32'h0);
    chk("rst_ID_PC", bus.ID_PC, 32'h0);
    chk("rst_ID_pred", {31'h0, bus.ID_predicted}, 32'h0);
    chk("rst_ID_PFC", bus.ID_PFC, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.EX_upd_valid = 1'b0;
    model_reset();
    #1;
    chk("rel_IF_PC", bus.IF_PC, 32'h0);
  endtask

  // Monitor: compares each registered result one step after the edge that produced it
  exp_t me;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        chk("sb_IF_PC", bus.IF_PC, me.if_pc);
        chk("sb_ID_inst", bus.ID_inst, me.id_inst);
        chk("sb_ID_PC", bus.ID_PC, me.id_pc);
        chk("sb_ID_pred", {31'h0, bus.ID_predicted}, {31'h0, me.id_pred});
        chk("sb_ID_PFC", bus.ID_PFC, me.id_pfc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stim();
    model_reset();
    do_reset(1'b0);

    repeat (3) tick();
    chk("seq_IF_PC", bus.IF_PC, 32'd3);
    chk("seq_ID_PC", bus.ID_PC, 32'd2);
    chk("seq_ID_pred", {31'h0, bus.ID_predicted}, 32'h0);

    // Mid-run reset with an update pending on the same edge
    repeat (2) tick();
    do_reset(1'b1);
    repeat (3) tick();
    chk("rst2_IF_PC", bus.IF_PC, 32'd3);
    chk("rst2_ID_PC", bus.ID_PC, 32'd2);
    redir(32'd7);
    chk("redir_bubble_inst", bus.ID_inst, 32'h0);
    tick();
    chk("discarded_upd_pred", {31'h0, bus.ID_predicted}, 32'h0);
    chk("discarded_upd_IF_PC", bus.IF_PC, 32'd8);

    // Trained branch at PC=5 -> 20
    upd(32'd5, 1'b1, 32'd20);
    upd(32'd5, 1'b1, 32'd20);
    redir(32'd5);
    tick();
    chk("br5_ID_PC", bus.ID_PC, 32'd5);
    chk("br5_ID_pred", {31'h0, bus.ID_predicted}, 32'h1);
    chk("br5_ID_PFC", bus.ID_PFC, 32'd20);
    chk("br5_IF_PC", bus.IF_PC, 32'd20);

    // Stall at PC=8, then stall combined with redirect
    redir(32'd7);
    tick();
    t_stall = 1; tick();
    t_stall = 1; tick();
    chk("stall_IF_PC", bus.IF_PC, 32'd8);
    chk("stall_ID_PC", bus.ID_PC, 32'd7);
    chk("stall_ID_inst", bus.ID_inst, imem(32'd7));
    t_stall = 1; t_redir = 1; t_pfc = 32'd40; tick();
    chk("stall_redir_IF_PC", bus.IF_PC, 32'd40);
    chk("stall_redir_ID_PC", bus.ID_PC, 32'h0);
    chk("stall_redir_ID_inst", bus.ID_inst, 32'h0);

    // Flush squashes the fetched word but PC advances
    t_flush = 1; t_fen = 1; t_fval = 32'hDEAD_BEEF; tick();
    chk("flush_ID_inst", bus.ID_inst, 32'h0);
    chk("flush_ID_pred", {31'h0, bus.ID_predicted}, 32'h0);
    chk("flush_IF_PC", bus.IF_PC, 32'd41);

    // Counter saturation at PC=3
    repeat (4) upd(32'd3, 1'b1, 32'd100);
    upd(32'd3, 1'b0, 32'd0);
    redir(32'd3);
    tick();
    chk("sat_pred_after_1nt", {31'h0, bus.ID_predicted}, 32'h1);
    chk("sat_PFC_after_1nt", bus.ID_PFC, 32'd100);
    upd(32'd3, 1'b0, 32'd0);
    redir(32'd3);
    tick();
    chk("sat_pred_after_2nt", {31'h0, bus.ID_predicted}, 32'h0);
    chk("sat_PFC_after_2nt", bus.ID_PFC, 32'd4);
    chk("sat_IF_PC_after_2nt", bus.IF_PC, 32'd4);

    // Same-cycle update/lookup, alias, wrap
    redir(32'd2);
    upd(32'd2, 1'b1, 32'd60);
    chk("same_cycle_pred", {31'h0, bus.ID_predicted}, 32'h0);
    chk("same_cycle_IF_PC", bus.IF_PC, 32'd3);
    upd(32'd2, 1'b1, 32'd60);
    redir(32'd18);
    tick();
    chk("alias_pred", {31'h0, bus.ID_predicted}, 32'h0);
    chk("alias_IF_PC", bus.IF_PC, 32'd19);
    redir(32'd2);
    tick();
    chk("pc2_pred", {31'h0, bus.ID_predicted}, 32'h1);
    chk("pc2_IF_PC", bus.IF_PC, 32'd60);
    redir(32'hFFFF_FFFF);
    tick();
    chk("wrap_IF_PC", bus.IF_PC, 32'h0);
    chk("wrap_ID_PC", bus.ID_PC, 32'hFFFF_FFFF);
    chk("wrap_ID_PFC", bus.ID_PFC, 32'h0);

    // Randomized traffic over a small PC range so indices alias often
    for (int i = 0; i < 400; i++) begin
      t_stall = ($urandom_range(0, 99) < 15);
      t_flush = ($urandom_range(0, 99) < 8);
      t_redir = ($urandom_range(0, 99) < 12);
      t_pfc   = ($urandom_range(0, 99) < 5) ? $urandom() : 32'($urandom_range(0, 63));
      t_uv    = ($urandom_range(0, 99) < 40);
      t_upc   = 32'($urandom_range(0, 63));
      t_ut    = 1'($urandom_range(0, 1));
      t_utgt  = 32'($urandom_range(0, 63));
      tick();
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected results never compared, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
Fetch stage plus IF/ID pipeline register. It sits directly upstream of the ID/EX buffer.
- Owns the PC register.
- Drives the instruction-memory address.
- Makes a dynamic branch prediction using a 2-bit BHT and a direct-mapped BTB.
- Registers instruction, PC, prediction flag and predicted-fetch-PC for the decode stage. ID later forwards the prediction flag and predicted PC as ID_predicted / ID_PFC_to_EX.
- Accepts redirects and predictor updates from EX.

Parameters:
- PC_W, 32, PC and target width.
- IDX_W, 4, predictor index bits; entries = 2**IDX_W.
- PC_INC, 1, sequential PC increment (word-addressed instruction memory).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- STALL  in  1  hazard unit: hold PC and IF/ID register.
- FLUSH  in  1  squash IF/ID contents (mispredict / jump).
- EX_redirect  in  1  load PC from EX_PFC.
- EX_PFC  in  PC_W  corrected fetch PC.
- EX_upd_valid  in  1  resolved branch/jump update.
- EX_upd_PC  in  PC_W  PC of resolved instruction.
- EX_upd_taken  in  1  actual outcome.
- EX_upd_target  in  PC_W  actual target.
- IF_PC  out  PC_W  instruction-memory address (current PC).
- IF_inst  in  32  instruction memory data, combinational read of IF_PC.
- ID_inst  out  32  registered instruction.
- ID_PC  out  PC_W  registered PC.
- ID_predicted  out  1  registered predict-taken flag.
- ID_PFC  out  PC_W  registered predicted next PC.

Behaviour:
- Reset (async, rst=1):
  - PC <= RESET_PC.
  - ID_inst, ID_PC, ID_predicted, ID_PFC <= 0 (instruction 0 is NOP).
  - All BHT counters <= 2'b01 (weakly not-taken).
  - All BTB valid bits <= 0.
  - Reset asserted mid-operation discards everything, including a pending update.
- Index and tag:
  - idx = PC[IDX_W-1:0].
  - tag = PC[PC_W-1:IDX_W].
- Prediction (combinational on the current PC): pred_taken = BTB valid[idx] && tag match && BHT[idx][1].
- Predicted next PC (pnext): BTB target if pred_taken, else PC+PC_INC (modulo 2**PC_W, wraps silently).
- Next-PC priority per cycle:
  1. EX_redirect: PC <= EX_PFC. Wins over STALL.
  2. STALL: PC holds.
  3. Otherwise: PC <= pnext.
- IF/ID register priority:
  1. FLUSH or EX_redirect: all ID_* <= 0.
  2. STALL: all ID_* hold.
  3. Otherwise: ID_inst <= IF_inst, ID_PC <= PC, ID_predicted <= pred_taken, ID_PFC <= pnext.
- Latency: one cycle from PC to ID outputs. Redirect penalty is one bubble in ID (the cycle after redirect).
- Predictor update, when EX_upd_valid is high (ignores STALL/FLUSH):
  - Counter at update index: taken → saturating increment, capped at 2'b11; not-taken → saturating decrement, floored at 2'b00.
  - If taken: BTB[idx] <= {valid=1, tag, EX_upd_target}.
  - If not-taken: BTB entry unchanged.
- Update and lookup in the same cycle to the same index: the lookup sees the pre-update value (no bypass). The update is visible from the next cycle.
- Aliasing between PCs with equal idx and different tag: tag mismatch gives a not-taken prediction; counter sharing is accepted.
- Simultaneous EX_redirect and EX_upd_valid: both take effect; the redirect target is unaffected by the update.

Decomposition:
- Shared package holds:
  - Counter encodings SNT=00, WNT=01, WT=10, ST=11.
  - NOP instruction constant (32'h0).
  - RESET_PC default.
- One sub-module, branch_predictor_table:
  - Contains the BHT/BTB arrays, lookup port and update port.
  - Has its own clk/rst with the same async reset.
- The top level holds the PC, the next-PC mux and the IF/ID register.

Test Plan:
- Reset mid-run, then release: IF_PC=0, ID_*=0. The next 3 cycles give IF_PC=1,2,3, with ID_PC trailing by one cycle and ID_predicted=0.
- Branch at PC=5 updated taken to target 20, twice (counter 01→10→11): on the next fetch of PC=5, ID_predicted=1, ID_PFC=20, and the following IF_PC=20.
- STALL high 2 cycles at PC=8: IF_PC stays 8 and ID_* hold. Same stall with EX_redirect=1, EX_PFC=40: next IF_PC=40, ID_*=0.
- FLUSH pulse with IF_inst=32'hDEADBEEF: ID_inst=0, ID_predicted=0. PC still advances.
- Counter saturation: 4 taken updates at PC=3 leave counter 11. Then 1 not-taken update gives 10, so the prediction is still taken. A 2nd not-taken gives 01 and a not-taken prediction with ID_PFC=4.
- Alias/same-cycle cases:
  - Update PC=2 while fetching PC=2: the same-cycle prediction uses the old value.
  - PC=18 (idx 2, different tag) predicts not-taken despite the taken entry for PC=2.
  - PC=32'hFFFFFFFF with no valid BTB entry wraps to IF_PC=0.
